// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types, forwarding encodings and mult/div latency defaults.
package hazard_ctrl_pkg;
    typedef enum logic {IDLE, BUSY} md_state_t;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;
    // Register 0 is hardwired, so a write to it is never a dependency.
    function automatic logic reg_hit(input logic we, input logic [4:0] wr, input logic [4:0] rd);
        return we && wr != 5'd0 && wr == rd;
    endfunction
endpackage

// File: rtl/muldiv_timer.sv
// muldiv_timer: tracks an in-flight multiply/divide and pulses done on its final execute cycle.
module muldiv_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op,
    output logic busy,
    output logic done
);
    localparam logic [5:0] MUL_LOAD = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    md_state_t state, state_nx;
    logic [5:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign busy = state == BUSY;
    assign done = busy && cnt == 6'd0;

    // A start is accepted when idle or in the done cycle; otherwise it is dropped.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (start && (!busy || done)) begin
            state_nx = BUSY;
            cnt_nx   = op ? DIV_LOAD : MUL_LOAD;
        end else if (done) begin
            state_nx = IDLE;
        end else if (busy) begin
            cnt_nx = cnt - 6'd1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load/branch/mult-div stalls and flushes for a 5-stage pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       MemtoReg_E,
    input  logic       MemtoReg_M,
    input  logic       Branch_D,
    input  logic       PCSrc_D,
    input  logic       MulDivStart_E,
    input  logic       MulDivOp_E,
    input  logic       MulDivUse_D,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       ForwardA_D,
    output logic       ForwardB_D,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       MulDivBusy,
    output logic       MulDivDone
);
    logic lwstall, brstall, mdstall, stall;

    muldiv_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MulDivStart_E),
        .op    (MulDivOp_E),
        .busy  (MulDivBusy),
        .done  (MulDivDone)
    );

    assign lwstall = reg_hit(MemtoReg_E, Rt_E, Rs_D) || reg_hit(MemtoReg_E, Rt_E, Rt_D);
    assign brstall = Branch_D && (reg_hit(RegWrite_E, WriteReg_E, Rs_D) || reg_hit(RegWrite_E, WriteReg_E, Rt_D) ||
                                  reg_hit(MemtoReg_M, WriteReg_M, Rs_D) || reg_hit(MemtoReg_M, WriteReg_M, Rt_D));
    assign mdstall = MulDivUse_D && MulDivBusy && !MulDivDone;
    assign stall   = rst_n && (lwstall || brstall || mdstall);

    // Reset holds both front registers flushed and every forward at the register file.
    assign StallF     = stall;
    assign StallD     = stall;
    assign FlushE     = !rst_n || stall;
    assign FlushD     = !rst_n || (PCSrc_D && !stall);
    assign ForwardA_D = rst_n && reg_hit(RegWrite_M, WriteReg_M, Rs_D);
    assign ForwardB_D = rst_n && reg_hit(RegWrite_M, WriteReg_M, Rt_D);
    assign ForwardA_E = !rst_n ? FWD_RF : reg_hit(RegWrite_M, WriteReg_M, Rs_E) ? FWD_M :
                        reg_hit(RegWrite_W, WriteReg_W, Rs_E) ? FWD_W : FWD_RF;
    assign ForwardB_E = !rst_n ? FWD_RF : reg_hit(RegWrite_M, WriteReg_M, Rt_E) ? FWD_M :
                        reg_hit(RegWrite_W, WriteReg_W, Rt_E) ? FWD_W : FWD_RF;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for forwarding, stalls, flushes and the mult/div timer.
module tb_hazard_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic Branch_D, PCSrc_D, MulDivStart_E, MulDivOp_E, MulDivUse_D;
    logic StallF, StallD, FlushD, FlushE, ForwardA_D, ForwardB_D, MulDivBusy, MulDivDone;
    logic [1:0] ForwardA_E, ForwardB_E;
    int checks = 0, failures = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .Branch_D(Branch_D), .PCSrc_D(PCSrc_D),
        .MulDivStart_E(MulDivStart_E), .MulDivOp_E(MulDivOp_E), .MulDivUse_D(MulDivUse_D),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed order: StallF StallD FlushD FlushE FwdA_D FwdB_D FwdA_E FwdB_E Busy Done
    task automatic expect_out(input string tag, input logic st, input logic fd, input logic fe,
                              input logic fad, input logic fbd, input logic [1:0] fae,
                              input logic [1:0] fbe, input logic bz, input logic dn);
        check(tag, {20'd0, StallF, StallD, FlushD, FlushE, ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E, MulDivBusy, MulDivDone},
              {20'd0, st, st, fd, fe, fad, fbd, fae, fbe, bz, dn});
    endtask

    task automatic clr();
        {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = '0;
        {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = '0;
        {Branch_D, PCSrc_D, MulDivStart_E, MulDivOp_E, MulDivUse_D} = '0;
    endtask

    task automatic start_op(input logic op);
        MulDivStart_E = 1'b1;
        MulDivOp_E = op;
        @(posedge clk);
        #1;
        MulDivStart_E = 1'b0;
    endtask

    initial begin
        clr();
        MemtoReg_E = 1; Rt_E = 5; Rs_D = 5; RegWrite_M = 1; WriteReg_M = 5; Rs_E = 5; PCSrc_D = 1;
        #2 expect_out("in_reset", 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        #1 expect_out("idle", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        MemtoReg_E = 1; Rt_E = 5; Rs_D = 5;
        #1 expect_out("load_use", 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        @(posedge clk); #1 clr();
        Rs_E = 5; RegWrite_W = 1; WriteReg_W = 5;
        #1 expect_out("load_use_fwd_w", 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);

        clr(); RegWrite_M = 1; RegWrite_W = 1; WriteReg_M = 7; WriteReg_W = 7; Rs_E = 7; Rt_E = 7; Rs_D = 7;
        #1 expect_out("double_m_pri", 0, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0);
        WriteReg_M = 0; WriteReg_W = 0; Rs_E = 0; Rt_E = 0; Rs_D = 0;
        #1 expect_out("reg0_nofwd", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        clr(); RegWrite_W = 1; WriteReg_W = 9; WriteReg_M = 9; Rt_E = 9;
        #1 expect_out("fwdb_w_only", 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0);
        clr(); RegWrite_M = 1; WriteReg_M = 4; Rt_D = 4; Rs_D = 2;
        #1 expect_out("fwdb_d", 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);

        clr(); Branch_D = 1; Rs_D = 3; RegWrite_E = 1; WriteReg_E = 3; PCSrc_D = 1;
        #1 expect_out("br_stall", 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        @(posedge clk); #1 RegWrite_E = 0;
        #1 expect_out("br_flush", 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        clr(); Branch_D = 1; Rt_D = 6; MemtoReg_M = 1; WriteReg_M = 6;
        #1 expect_out("br_load_m", 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        clr(); Branch_D = 1; Rs_D = 8; RegWrite_E = 1; WriteReg_E = 9;
        #1 expect_out("br_nohaz", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        clr(); MemtoReg_E = 1; Rt_E = 0; Rs_D = 0; Rt_D = 0;
        #1 expect_out("reg0_nostall", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        clr();
        start_op(1'b1);
        MulDivUse_D = 1;
        for (int i = 1; i <= 32; i++) begin
            #1 expect_out($sformatf("div_c%0d", i), i < 32, 0, i < 32, 0, 0, 2'b00, 2'b00, 1, i == 32);
            @(posedge clk); #1;
        end
        expect_out("div_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        clr();
        start_op(1'b0);
        for (int i = 1; i <= 8; i++) begin
            MulDivStart_E = (i == 2) || (i == 4);
            MulDivOp_E = (i == 2);
            #1 expect_out($sformatf("b2b_c%0d", i), 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, i == 4 || i == 8);
            @(posedge clk); #1;
        end
        MulDivStart_E = 0;
        #1 expect_out("b2b_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        clr();
        start_op(1'b1);
        MulDivUse_D = 1;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 expect_out("rst_mid_div", 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 26; i++) begin
            #1 expect_out($sformatf("post_rst_c%0d", i), 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
